pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 125 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: valid/ready payload register with delay-slot flag tracking.
// Define PIPE_STAGE_SKID_EN to add a skid register and a registered in_ready.
module pipe_stage_buf #(
    parameter int WIDTH  = 128,
    parameter int DS_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             en_pc,
    input  logic             next_ds_i,
    output logic             ds_o,
    output logic [1:0]       occ
);

    logic              main_vld_q, main_vld_d;
    logic [WIDTH-1:0]  main_data_q, main_data_d;
    logic              pend_q, pend_d;
    logic              ds_q, ds_d;
    logic [DS_LAT-1:0] en_pipe_q, en_pipe_d;
    logic              accept, retire, tap;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0]  skid_data_q, skid_data_d;

    // skid_vld_q is itself a flop, so in_ready never sees out_ready combinationally
    assign in_ready = ~skid_vld_q;
    assign occ      = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
`else
    assign in_ready = out_ready | ~main_vld_q;
    assign occ      = {1'b0, main_vld_q};
`endif

    assign accept    = in_valid & in_ready;
    assign retire    = main_vld_q & out_ready;
    assign tap       = en_pipe_q[DS_LAT-1];
    assign out_valid = main_vld_q;
    assign out_data  = main_data_q;
    assign ds_o      = ds_q;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (!main_vld_q || retire) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
                skid_data_d = '0;
            end else begin
                main_vld_d  = accept;
                main_data_d = accept ? in_data : '0;
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
        end
`else
        if (!main_vld_q || retire) begin
            main_vld_d  = accept;
            main_data_d = accept ? in_data : '0;
        end
`endif

        en_pipe_d[0] = en_pc;
        for (int i = 1; i < DS_LAT; i++) en_pipe_d[i] = en_pipe_q[i-1];

        ds_d   = ds_q;
        pend_d = pend_q;
        if (tap) begin
            ds_d   = pend_q | next_ds_i;
            pend_d = 1'b0;
        end else if (accept) begin
            pend_d = pend_q | next_ds_i;
        end

        // Flush wins over everything, including a beat accepted this cycle
        if (flush) begin
            main_vld_d  = 1'b0;
            main_data_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_d  = 1'b0;
            skid_data_d = '0;
`endif
            en_pipe_d   = '0;
            ds_d        = 1'b0;
            pend_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
`endif
            en_pipe_q   <= '0;
            ds_q        <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
`endif
            en_pipe_q   <= en_pipe_d;
            ds_q        <= ds_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized + directed bench for pipe_stage_buf; a queue model of held beats is the scoreboard.
module tb_pipe_stage_buf;
    localparam int W   = 8;
    localparam int DSL = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         en_pc = 1'b0, next_ds_i = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, ds_o;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: beats in flight, en_pc history, delay-slot bits
    logic [W-1:0] mq[$];
    logic         hist[$];
    logic         m_pend = 1'b0;
    logic         m_ds = 1'b0;

    pipe_stage_buf #(.WIDTH(W), .DS_LAT(DSL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .en_pc(en_pc), .next_ds_i(next_ds_i), .ds_o(ds_o), .occ(occ)
    );

    always #5 clk = ~clk;

    function automatic logic exp_in_ready();
`ifdef PIPE_STAGE_SKID_EN
        return mq.size() < 2;
`else
        return out_ready || mq.size() == 0;
`endif
    endfunction

    task automatic clear_model();
        mq.delete();
        hist.delete();
        for (int i = 0; i < DSL; i++) hist.push_back(1'b0);
        m_pend = 1'b0;
        m_ds   = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model, advanced on every edge
    initial begin
        logic acc, ret, tp;
        clear_model();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                clear_model();
            end else begin
                acc = in_valid && exp_in_ready();
                ret = (mq.size() > 0) && out_ready;
                tp  = hist.pop_front();
                hist.push_back(en_pc);
                if (flush) begin
                    clear_model();
                end else begin
                    if (ret) void'(mq.pop_front());
                    if (acc) mq.push_back(in_data);
                    if (tp) begin
                        m_ds   = m_pend | next_ds_i;
                        m_pend = 1'b0;
                    end else if (acc) begin
                        m_pend = m_pend | next_ds_i;
                    end
                end
            end
        end
    end

    // Monitor: compare DUT outputs to the model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", int'(out_valid), int'(mq.size() > 0));
            chk("out_data", int'(out_data), mq.size() > 0 ? int'(mq[0]) : 0);
            chk("occ", int'(occ), mq.size());
            chk("in_ready", int'(in_ready), int'(exp_in_ready()));
            chk("ds_o", int'(ds_o), int'(m_ds));
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic en, input logic nds);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; out_ready = ordy;
        flush = fl; en_pc = en; next_ds_i = nds;
    endtask

    initial begin
        // reset state and in_ready during reset
        #2;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_occ", int'(occ), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single beat, latency 1, then NOP
        cyc(1, 8'h5A, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);

        // fill both entries, then drain in order
        cyc(1, 8'h11, 0, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);

        // flush beats a simultaneous accept
        cyc(1, 8'h11, 0, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0, 0);
        cyc(1, 8'h33, 0, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);

        // delay-slot flag: accept with next_ds_i, en_pc one cycle later
        cyc(1, 8'h44, 1, 0, 0, 1);
        cyc(0, 8'h00, 1, 0, 1, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 1, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);

        // same-cycle in_ready response to out_ready with a held beat
        cyc(1, 8'h66, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // async reset between edges while holding beats
        cyc(1, 8'h11, 0, 0, 0, 1);
        cyc(1, 8'h22, 0, 0, 1, 1);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_occ", int'(occ), 0);
        chk("arst_ds_o", int'(ds_o), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);

        // random phases with varying downstream backpressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 400; n++) begin
                cyc($urandom_range(0, 3) != 0,
                    W'($urandom),
                    $urandom_range(0, 3) < ph + 1 - (ph == 3 ? 1 : 0),
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1);
            end
        end

        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
